// File: rtl/ticket_booking_fsm_pkg.sv
// ============================================================================
//  Module      : ticket_pkg
//  Description : Shared types and defaults for the ticket booking controller.
//                Holds the FSM state encoding, the default price / coin /
//                credit-width constants (also consumed by the display block)
//                and a saturating add helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ticket_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        REFUND   = 2'd3
    } state_t;

    localparam int c_DEFAULT_PRICE    = 30;
    localparam int c_DEFAULT_COIN     = 10;
    localparam int c_DEFAULT_CREDIT_W = 8;

    // a + b clamped to max, written so the intermediate sum never wraps.
    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned max);
        if ((b >= max) || (a > (max - b)))
            return max;
        return a + b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ticket_booking_fsm_if.sv
// ============================================================================
//  Module      : ticket_booking_fsm_if
//  Description : Bundle of debounced button pulses (toward the controller)
//                and the display/dispenser outputs (from the controller).
//                master : pulse source / output consumer
//                slave  : the booking controller
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ticket_booking_fsm_if #(
    parameter int CREDIT_W = 8,
    parameter int SEAT_W   = 5
);
    logic                book_pulse;
    logic                coin_pulse;
    logic                confirm_pulse;
    logic                cancel_pulse;
    logic                ticket_out;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_out;
    logic [CREDIT_W-1:0] credit;
    logic [SEAT_W-1:0]   seats_left;
    logic                sold_out;
    logic                busy;

    modport master (
        output book_pulse, coin_pulse, confirm_pulse, cancel_pulse,
        input  ticket_out, change_valid, change_out, credit,
               seats_left, sold_out, busy
    );

    modport slave (
        input  book_pulse, coin_pulse, confirm_pulse, cancel_pulse,
        output ticket_out, change_valid, change_out, credit,
               seats_left, sold_out, busy
    );
endinterface

`default_nettype wire

// File: rtl/ticket_timeout_ctr.sv
// ============================================================================
//  Module      : ticket_timeout_ctr
//  Description : Loadable up-counter with clear, enable and terminal-count
//                flag. Stops at TIMEOUT_CYCLES-1 so the flag stays asserted
//                until the owner clears it.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_clr         - force count to 0 (highest priority)
//                i_load/_val   - load an arbitrary count
//                i_en          - count up by one
//                o_tc          - count == TIMEOUT_CYCLES-1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ticket_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire                               clk,
    input  wire                               rst,
    input  wire                               i_clr,
    input  wire                               i_load,
    input  wire [$clog2(TIMEOUT_CYCLES)-1:0]  i_load_val,
    input  wire                               i_en,
    output logic                              o_tc
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_en && !o_tc)
            r_count <= r_count + CNT_W'(1);
    end

    assign o_tc = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/ticket_booking_fsm.sv
// ============================================================================
//  Module      : ticket_booking_fsm
//  Description : Ticket sales controller. Takes a booking, accumulates coin
//                credit, dispenses a ticket on confirm (with change) or
//                refunds on cancel / inactivity timeout. Seat pool is finite
//                and only restored by reset.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - slave side of ticket_booking_fsm_if (pulses in,
//                           ticket/change/credit/seat status out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ticket_booking_fsm
    import ticket_pkg::*;
#(
    parameter int NUM_SEATS      = 16,
    parameter int TICKET_PRICE   = c_DEFAULT_PRICE,
    parameter int COIN_VALUE     = c_DEFAULT_COIN,
    parameter int CREDIT_W       = c_DEFAULT_CREDIT_W,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire                   clk,
    input  wire                   rst,
    ticket_booking_fsm_if.slave   bus
);
    localparam int SEAT_W = $clog2(NUM_SEATS + 1);
    localparam int unsigned c_CREDIT_MAX = (2 ** CREDIT_W) - 1;

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [SEAT_W-1:0]   r_seats, w_seats_nxt;
    logic                r_ticket, w_ticket_nxt;
    logic                r_chg_valid, w_chg_valid_nxt;
    logic [CREDIT_W-1:0] r_chg, w_chg_nxt;
    logic                r_busy;
    logic                r_sold_out;

    logic                w_ctr_clr, w_ctr_en, w_ctr_tc;
    logic [CREDIT_W-1:0] w_credit_plus;
    logic [CREDIT_W-1:0] w_change;
    logic [CREDIT_W-1:0] w_refund;

    ticket_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_ctr_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_ctr_en),
        .o_tc       (w_ctr_tc)
    );

    assign w_credit_plus = CREDIT_W'(sat_add(32'(r_credit), COIN_VALUE, c_CREDIT_MAX));
    assign w_change      = r_credit - CREDIT_W'(TICKET_PRICE);
    // A coin arriving with cancel still counts toward the refund.
    assign w_refund      = bus.coin_pulse ? w_credit_plus : r_credit;

    always_comb begin
        w_state_nxt     = r_state;
        w_credit_nxt    = r_credit;
        w_seats_nxt     = r_seats;
        w_ticket_nxt    = 1'b0;
        w_chg_valid_nxt = 1'b0;
        w_chg_nxt       = '0;
        w_ctr_clr       = 1'b0;
        w_ctr_en        = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.book_pulse && !r_sold_out) begin
                    w_state_nxt  = COLLECT;
                    w_credit_nxt = '0;
                    w_ctr_clr    = 1'b1;
                end
            end
            COLLECT: begin
                w_ctr_en = 1'b1;
                if (bus.cancel_pulse) begin
                    w_state_nxt     = REFUND;
                    w_credit_nxt    = '0;
                    w_chg_valid_nxt = (w_refund != '0);
                    w_chg_nxt       = w_refund;
                end else if (bus.coin_pulse) begin
                    // Coin wins over a simultaneous confirm; confirm is dropped.
                    w_credit_nxt = w_credit_plus;
                    w_ctr_clr    = 1'b1;
                end else if (bus.confirm_pulse &&
                             (r_credit >= CREDIT_W'(TICKET_PRICE))) begin
                    w_state_nxt     = DISPENSE;
                    w_ticket_nxt    = 1'b1;
                    w_chg_valid_nxt = (w_change != '0);
                    w_chg_nxt       = w_change;
                    w_seats_nxt     = r_seats - SEAT_W'(1);
                end else if (w_ctr_tc) begin
                    w_state_nxt     = REFUND;
                    w_credit_nxt    = '0;
                    w_chg_valid_nxt = (r_credit != '0);
                    w_chg_nxt       = r_credit;
                end
            end
            DISPENSE: begin
                w_state_nxt  = IDLE;
                w_credit_nxt = '0;
            end
            REFUND: begin
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_credit    <= '0;
            r_seats     <= SEAT_W'(NUM_SEATS);
            r_ticket    <= 1'b0;
            r_chg_valid <= 1'b0;
            r_chg       <= '0;
            r_busy      <= 1'b0;
            r_sold_out  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_credit    <= w_credit_nxt;
            r_seats     <= w_seats_nxt;
            r_ticket    <= w_ticket_nxt;
            r_chg_valid <= w_chg_valid_nxt;
            r_chg       <= w_chg_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_sold_out  <= (w_seats_nxt == '0);
        end
    end

    assign bus.ticket_out   = r_ticket;
    assign bus.change_valid = r_chg_valid;
    assign bus.change_out   = r_chg;
    assign bus.credit       = r_credit;
    assign bus.seats_left   = r_seats;
    assign bus.sold_out     = r_sold_out;
    assign bus.busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ticket_booking_fsm.sv
// ============================================================================
//  Module      : tb_ticket_booking_fsm
//  Description : Self-checking bench for ticket_booking_fsm (NUM_SEATS=2,
//                TIMEOUT_CYCLES=20). Expected ticket/change events are queued
//                as stimulus is driven and matched by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ticket_booking_fsm;

    localparam int NUM_SEATS = 2;
    localparam int TIMEOUT   = 20;
    localparam int CREDIT_W  = 8;
    localparam int SEAT_W    = $clog2(NUM_SEATS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ticket_booking_fsm_if #(.CREDIT_W(CREDIT_W), .SEAT_W(SEAT_W)) bus ();

    ticket_booking_fsm #(
        .NUM_SEATS      (NUM_SEATS),
        .TICKET_PRICE   (30),
        .COIN_VALUE     (10),
        .CREDIT_W       (CREDIT_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic                ticket;
        logic                cv;
        logic [CREDIT_W-1:0] chg;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push_exp(input logic t, input logic v, input logic [CREDIT_W-1:0] c);
        exp_t e;
        e.ticket = t; e.cv = v; e.chg = c;
        q.push_back(e);
    endtask

    // Output-event monitor: every ticket/change pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ticket_out || bus.change_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: ticket=%0b cv=%0b chg=%0d with nothing expected",
                             bus.ticket_out, bus.change_valid, bus.change_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.ticket_out !== e.ticket || bus.change_valid !== e.cv ||
                        bus.change_out !== e.chg) begin
                        failures++;
                        $display("FAIL event: got ticket=%0b cv=%0b chg=%0d, want ticket=%0b cv=%0b chg=%0d",
                                 bus.ticket_out, bus.change_valid, bus.change_out,
                                 e.ticket, e.cv, e.chg);
                    end
                end
            end
            checks++;
            if (!bus.change_valid && bus.change_out !== '0) begin
                failures++;
                $display("FAIL change_zero: change_out=%0d while change_valid=0", bus.change_out);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of pulses starting at posedge+1; returns at the next posedge+1.
    task automatic cyc(input logic b, input logic c, input logic cf, input logic cn);
        bus.book_pulse = b; bus.coin_pulse = c; bus.confirm_pulse = cf; bus.cancel_pulse = cn;
        @(posedge clk); #1;
        bus.book_pulse = 0; bus.coin_pulse = 0; bus.confirm_pulse = 0; bus.cancel_pulse = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.credit !== 8'd0 || bus.seats_left !== 2'd2 || bus.sold_out !== 1'b0 ||
            bus.busy !== 1'b0 || bus.ticket_out !== 1'b0 || bus.change_valid !== 1'b0 ||
            bus.change_out !== 8'd0) begin
            failures++;
            $display("FAIL reset: credit=%0d seats=%0d sold=%0b busy=%0b tk=%0b cv=%0b chg=%0d, want 0 2 0 0 0 0 0",
                     bus.credit, bus.seats_left, bus.sold_out, bus.busy,
                     bus.ticket_out, bus.change_valid, bus.change_out);
        end
    endtask

    task automatic test_normal_sale();
        do_reset();
        cyc(1, 0, 0, 0);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL book_busy: busy=%0b want 1", bus.busy);
        end
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        checks++;
        if (bus.credit !== 8'd30) begin
            failures++; $display("FAIL credit3: credit=%0d want 30", bus.credit);
        end
        push_exp(1, 0, 0);
        cyc(0, 0, 1, 0);
        checks++;
        if (bus.ticket_out !== 1'b1 || bus.seats_left !== 2'd1 || bus.change_valid !== 1'b0) begin
            failures++;
            $display("FAIL normal_sale: tk=%0b seats=%0d cv=%0b want 1 1 0",
                     bus.ticket_out, bus.seats_left, bus.change_valid);
        end
        idle(1);
        checks++;
        if (bus.busy !== 1'b0 || bus.credit !== 8'd0 || bus.ticket_out !== 1'b0) begin
            failures++;
            $display("FAIL sale_idle: busy=%0b credit=%0d tk=%0b want 0 0 0",
                     bus.busy, bus.credit, bus.ticket_out);
        end
    endtask

    task automatic test_overpay();
        do_reset();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        push_exp(1, 1, 10);
        cyc(0, 0, 1, 0);
        checks++;
        if (bus.ticket_out !== 1'b1 || bus.change_valid !== 1'b1 || bus.change_out !== 8'd10) begin
            failures++;
            $display("FAIL overpay: tk=%0b cv=%0b chg=%0d want 1 1 10",
                     bus.ticket_out, bus.change_valid, bus.change_out);
        end
        idle(1);
        checks++;
        if (bus.credit !== 8'd0) begin
            failures++; $display("FAIL overpay_credit: credit=%0d want 0", bus.credit);
        end
    endtask

    task automatic test_insufficient();
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        idle(1);
        checks++;
        if (bus.ticket_out !== 1'b0 || bus.busy !== 1'b1 || bus.credit !== 8'd20) begin
            failures++;
            $display("FAIL insufficient: tk=%0b busy=%0b credit=%0d want 0 1 20",
                     bus.ticket_out, bus.busy, bus.credit);
        end
        push_exp(0, 1, 20);
        cyc(0, 0, 0, 1);
        checks++;
        if (bus.change_valid !== 1'b1 || bus.change_out !== 8'd20) begin
            failures++;
            $display("FAIL cancel: cv=%0b chg=%0d want 1 20", bus.change_valid, bus.change_out);
        end
        idle(1);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL cancel_idle: busy=%0b want 0", bus.busy);
        end
    endtask

    task automatic test_collision();
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        checks++;
        if (bus.credit !== 8'd30 || bus.ticket_out !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL coin_confirm: credit=%0d tk=%0b busy=%0b want 30 0 1",
                     bus.credit, bus.ticket_out, bus.busy);
        end
        push_exp(1, 0, 0);
        cyc(0, 0, 1, 0);
        checks++;
        if (bus.ticket_out !== 1'b1) begin
            failures++; $display("FAIL confirm_after: tk=%0b want 1", bus.ticket_out);
        end
        idle(1);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        push_exp(0, 1, 20);
        cyc(0, 1, 0, 1);
        checks++;
        if (bus.change_valid !== 1'b1 || bus.change_out !== 8'd20 || bus.credit !== 8'd0) begin
            failures++;
            $display("FAIL cancel_coin: cv=%0b chg=%0d credit=%0d want 1 20 0",
                     bus.change_valid, bus.change_out, bus.credit);
        end
        idle(1);
    endtask

    task automatic test_timeout();
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        idle(TIMEOUT - 1);
        checks++;
        if (bus.busy !== 1'b1 || bus.change_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: busy=%0b cv=%0b want 1 0", bus.busy, bus.change_valid);
        end
        push_exp(0, 1, 10);
        idle(1);
        checks++;
        if (bus.change_valid !== 1'b1 || bus.change_out !== 8'd10 || bus.credit !== 8'd0) begin
            failures++;
            $display("FAIL timeout_refund: cv=%0b chg=%0d credit=%0d want 1 10 0",
                     bus.change_valid, bus.change_out, bus.credit);
        end
        idle(1);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL timeout_idle: busy=%0b want 0", bus.busy);
        end
    endtask

    task automatic test_sold_out();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            cyc(1, 0, 0, 0);
            for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
            push_exp(1, 0, 0);
            cyc(0, 0, 1, 0);
            checks++;
            if (bus.seats_left !== SEAT_W'(1 - s) || bus.sold_out !== (s == 1)) begin
                failures++;
                $display("FAIL sale%0d_seats: seats=%0d sold=%0b want %0d %0b",
                         s, bus.seats_left, bus.sold_out, 1 - s, (s == 1));
            end
            idle(1);
        end
        cyc(1, 0, 0, 0);
        checks++;
        if (bus.busy !== 1'b0 || bus.sold_out !== 1'b1) begin
            failures++;
            $display("FAIL soldout_book: busy=%0b sold=%0b want 0 1", bus.busy, bus.sold_out);
        end
        cyc(0, 1, 1, 0);
        idle(1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        do_reset();
        checks++;
        if (bus.credit !== 8'd0 || bus.seats_left !== 2'd2 || bus.busy !== 1'b0 ||
            bus.change_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: credit=%0d seats=%0d busy=%0b cv=%0b want 0 2 0 0",
                     bus.credit, bus.seats_left, bus.busy, bus.change_valid);
        end
        idle(3);
    endtask

    initial begin
        bus.book_pulse = 0; bus.coin_pulse = 0; bus.confirm_pulse = 0; bus.cancel_pulse = 0;
        #1;
        test_reset();
        test_normal_sale();
        test_overpay();
        test_insufficient();
        test_collision();
        test_timeout();
        test_sold_out();
        test_reset_mid();
        idle(2);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected events never seen, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ticket_booking_fsm.md
Name: ticket_booking_fsm

Overview:
- Transaction controller that consumes the single-cycle clean pulses produced by the button debounce stage (one debounce instance per button).
- Sells tickets against a finite seat pool: accepts a booking request, accumulates coin credit, dispenses a ticket on confirm, and returns change or a refund.
- Sits directly downstream of the debouncers and drives the display and dispenser logic.

Parameters:
- NUM_SEATS, 16, initial seat pool size (>=1)
- TICKET_PRICE, 30, credit units per ticket (>0, < 2^CREDIT_W)
- COIN_VALUE, 10, credit units added per coin pulse (>0)
- CREDIT_W, 8, credit and change width
- TIMEOUT_CYCLES, 1000000, idle cycles in COLLECT before automatic refund (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- book_pulse  in  1  clean pulse: start a booking
- coin_pulse  in  1  clean pulse: one coin inserted
- confirm_pulse  in  1  clean pulse: pay and issue ticket
- cancel_pulse  in  1  clean pulse: abort the transaction
- ticket_out  out  1  one-cycle pulse: dispense one ticket
- change_valid  out  1  one-cycle pulse: change_out is meaningful
- change_out  out  CREDIT_W  amount returned; 0 when change_valid=0
- credit  out  CREDIT_W  current accumulated credit
- seats_left  out  $clog2(NUM_SEATS+1)  remaining seats
- sold_out  out  1  high when seats_left==0
- busy  out  1  high whenever state!=IDLE

Behaviour:
- Clock and reset: single clock (clk). Reset (rst) is synchronous and active-high.
- Reset state: state=IDLE, credit=0, seats_left=NUM_SEATS, timeout count=0, ticket_out=0, change_valid=0, change_out=0, busy=0.
- Reset mid-transaction discards credit and issues no refund (documented limitation).
- Registers: all outputs are registered. Inputs are sampled on the rising edge of clk. A transition taken at edge k is visible in the cycle after edge k.
- State IDLE:
  - book_pulse with sold_out=0 -> COLLECT; credit=0; timeout count=0.
  - All other pulses are ignored.
  - book_pulse while sold_out=1 is ignored.
- State COLLECT, evaluated in this order each cycle:
  1. cancel_pulse -> REFUND. Refund amount = credit + (coin_pulse ? COIN_VALUE : 0), saturated.
  2. coin_pulse -> credit += COIN_VALUE, saturating at 2^CREDIT_W-1. A confirm_pulse in the same cycle is discarded.
  3. confirm_pulse with credit>=TICKET_PRICE -> DISPENSE. If credit<TICKET_PRICE, confirm is ignored and the state stays COLLECT.
  4. book_pulse is ignored.
  - Timeout: the count resets to 0 on any accepted coin and otherwise increments. When count reaches TIMEOUT_CYCLES-1 with no pulse, go to REFUND with amount=credit.
- State DISPENSE (exactly one cycle):
  - ticket_out=1.
  - change_out=credit-TICKET_PRICE; change_valid=1 only if that value is nonzero.
  - seats_left decrements by 1 (guaranteed >0 here).
  - credit is cleared at the exit edge.
  - All input pulses are ignored. Next state is IDLE.
- State REFUND (exactly one cycle):
  - change_out=refund amount; change_valid=1 only if the amount is nonzero.
  - credit=0; ticket_out=0.
  - All input pulses are ignored. Next state is IDLE.
- Output rules:
  - sold_out updates in the same cycle seats_left reaches 0.
  - Once sold out, no further transactions start; only reset restores seats.
  - change_out is forced to 0 in every cycle where change_valid=0.
- Arithmetic: unsigned. Saturation prevents credit wrap-around. Subtraction in DISPENSE cannot underflow because confirm is gated by credit>=TICKET_PRICE.

Decomposition:
- Shared package ticket_pkg:
  - state enum {IDLE, COLLECT, DISPENSE, REFUND}, 2-bit encoding.
  - Default price, coin value and credit width constants, shared with the display block.
- One sub-module: ticket_timeout_ctr. Loadable up-counter with clear, enable and a terminal-count flag, parameterised by TIMEOUT_CYCLES.
- Everything else is inline.

Test Plan (bench overrides: NUM_SEATS=2, TIMEOUT_CYCLES=20):
- Normal sale: book, 3 coins, confirm -> one ticket_out pulse the cycle after confirm; change_valid=0; seats_left 2->1; returns to IDLE.
- Overpay: book, 4 coins, confirm -> ticket_out=1 and change_valid=1 with change_out=10 in the same cycle; credit=0 afterwards.
- Insufficient credit: book, 2 coins, confirm -> no ticket and state stays COLLECT. Then cancel -> change_valid=1, change_out=20.
- Collision cases:
  - coin and confirm in the same cycle with credit=20 -> credit=30, no ticket.
  - A further confirm -> ticket.
  - cancel with coin in the same cycle at credit=10 -> change_out=20.
- Timeout: book, 1 coin, then 20 idle cycles -> REFUND with change_out=10; busy drops the following cycle.
- Sold out and reset:
  - Two complete sales -> sold_out=1, and a further book is ignored (busy stays 0).
  - rst asserted during COLLECT with credit=20 -> next cycle credit=0, seats_left=2, state IDLE, no change_valid pulse.
